// File: rtl/imem_boot_loader.sv
// Boot loader that streams a framed byte image into the MIPS core's instruction
// memory and keeps the core in reset until a load completes with a good checksum.
module imem_boot_loader #(
   parameter int NMEM = 20,
   parameter int AW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          start,
   output logic [AW-1:0] im_add,
   output logic [31:0]   im_data,
   output logic          im_en,
   output logic          im_rd_wr,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   localparam logic [2:0] S_HDR_HI = 3'd0;
   localparam logic [2:0] S_HDR_LO = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CSUM   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [15:0]   count_q, count_d;
   logic [1:0]    bidx_q, bidx_d;
   logic [15:0]   widx_q, widx_d;
   logic [31:0]   asm_q, asm_d;
   logic [7:0]    csum_q, csum_d;
   logic          en_q, en_d;
   logic [AW-1:0] add_q, add_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          ready_q, ready_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          xfer;
   logic [15:0]   hdrCount;
   logic [31:0]   word;

   assign xfer     = in_valid & ready_q;
   assign hdrCount = {count_q[15:8], in_data};
   assign word     = {asm_q[23:0], in_data};

   // Next-state logic: at most one byte is consumed per edge, and the write
   // strobe is registered so it lands in the cycle after the word's last byte.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bidx_d  = bidx_q;
      widx_d  = widx_q;
      asm_d   = asm_q;
      csum_d  = csum_q;
      en_d    = 1'b0;
      add_d   = add_q;
      wdata_d = wdata_q;

      case (state_q)
         S_HDR_HI: begin
            if (xfer) begin
               count_d = {in_data, 8'h00};
               csum_d  = csum_q ^ in_data;
               state_d = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (xfer) begin
               count_d = hdrCount;
               csum_d  = csum_q ^ in_data;
               if (hdrCount > 16'(NMEM)) begin
                  state_d = S_ERROR;
               end else if (hdrCount == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               csum_d = csum_q ^ in_data;
               asm_d  = word;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  en_d    = 1'b1;
                  add_d   = AW'({widx_q, 2'b00});
                  wdata_d = word;
                  widx_d  = widx_q + 16'd1;
                  if ((widx_q + 16'd1) == count_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_HDR_HI;
               count_d = 16'd0;
               bidx_d  = 2'd0;
               widx_d  = 16'd0;
               asm_d   = 32'd0;
               csum_d  = 8'd0;
            end
         end
         default: begin
            state_d = S_HDR_HI;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they flip on the same
   // edge as the state itself, i.e. one cycle after the deciding transfer.
   always_comb begin
      ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                (state_d == S_DATA)   || (state_d == S_CSUM);
      hold_d  = (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
      err_d   = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_HDR_HI;
         count_q <= 16'd0;
         bidx_q  <= 2'd0;
         widx_q  <= 16'd0;
         asm_q   <= 32'd0;
         csum_q  <= 8'd0;
         en_q    <= 1'b0;
         add_q   <= '0;
         wdata_q <= 32'd0;
         ready_q <= 1'b1;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bidx_q  <= bidx_d;
         widx_q  <= widx_d;
         asm_q   <= asm_d;
         csum_q  <= csum_d;
         en_q    <= en_d;
         add_q   <= add_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = ready_q;
   assign im_add   = add_q;
   assign im_data  = wdata_q;
   assign im_en    = en_q;
   assign im_rd_wr = en_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
